// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: bus commands, tag width and
// the requester-ownership type stored in the outstanding-load tag table.
package mem_arb_pkg;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam int MEM_TAG_W = 4;
  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 64;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_if.sv
// Request/response bundle between the two requesters, memory and mem_arb.
// slave is the arbiter's view; master is the view of the surrounding system.
interface mem_arb_if #(
  parameter int TAG_W = mem_arb_pkg::MEM_TAG_W
) ();

  logic [1:0]        Imem_cmd_i;
  logic [63:0]       Imem_addr_i;
  logic [1:0]        Dmem_cmd_i;
  logic [63:0]       Dmem_addr_i;
  logic [63:0]       Dmem_data_i;
  logic [TAG_W-1:0]  mem_response_i;
  logic [63:0]       mem_data_i;
  logic [TAG_W-1:0]  mem_tag_i;

  logic [1:0]        mem_cmd_o;
  logic [63:0]       mem_addr_o;
  logic [63:0]       mem_data_o;
  logic [TAG_W-1:0]  Imem_response_o;
  logic [TAG_W-1:0]  Dmem_response_o;
  logic [TAG_W-1:0]  Imem_tag_o;
  logic [63:0]       Imem_data_o;
  logic [TAG_W-1:0]  Dmem_tag_o;
  logic [63:0]       Dmem_data_o;
  logic [TAG_W-1:0]  outstanding_o;
  logic              tag_err_o;

  modport slave (
    input  Imem_cmd_i, Imem_addr_i, Dmem_cmd_i, Dmem_addr_i, Dmem_data_i,
    input  mem_response_i, mem_data_i, mem_tag_i,
    output mem_cmd_o, mem_addr_o, mem_data_o, Imem_response_o, Dmem_response_o,
    output Imem_tag_o, Imem_data_o, Dmem_tag_o, Dmem_data_o, outstanding_o, tag_err_o
  );

  modport master (
    output Imem_cmd_i, Imem_addr_i, Dmem_cmd_i, Dmem_addr_i, Dmem_data_i,
    output mem_response_i, mem_data_i, mem_tag_i,
    input  mem_cmd_o, mem_addr_o, mem_data_o, Imem_response_o, Dmem_response_o,
    input  Imem_tag_o, Imem_data_o, Dmem_tag_o, Dmem_data_o, outstanding_o, tag_err_o
  );

endinterface

// File: rtl/mem_arb_tag_tbl.sv
// Outstanding-load tag table: one {valid, owner} entry per nonzero tag.
// Allocation takes priority over a same-tag clear in the same cycle.
module mem_tag_tbl
  import mem_arb_pkg::*;
#(
  parameter int TAG_W = mem_arb_pkg::MEM_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_en_i,
  input  logic [TAG_W-1:0] alloc_tag_i,
  input  owner_e           alloc_owner_i,
  output logic             alloc_busy_o,
  input  logic [TAG_W-1:0] lkup_tag_i,
  input  logic             clr_en_i,
  output logic             valid_o,
  output owner_e           owner_o
);

  localparam int N_ENT = (1 << TAG_W) - 1;

  logic [N_ENT:1] valid_q, valid_d;
  logic [N_ENT:1] owner_q, owner_d;
  logic [N_ENT:0] valid_ext, owner_ext;

  for (genvar gi = 1; gi <= N_ENT; gi++) begin : g_ent
    logic hit_alloc, hit_clr;
    assign hit_alloc    = alloc_en_i && (alloc_tag_i == TAG_W'(gi));
    assign hit_clr      = clr_en_i && (lkup_tag_i == TAG_W'(gi));
    assign valid_d[gi]  = hit_alloc | (valid_q[gi] & ~hit_clr);
    assign owner_d[gi]  = hit_alloc ? logic'(alloc_owner_i) : owner_q[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  // Tag 0 maps to a permanently invalid slot, so lookups need no guard.
  assign valid_ext    = {valid_q, 1'b0};
  assign owner_ext    = {owner_q, 1'b0};
  assign valid_o      = valid_ext[lkup_tag_i];
  assign owner_o      = owner_e'(owner_ext[lkup_tag_i]);
  assign alloc_busy_o = valid_ext[alloc_tag_i];

endmodule

// File: rtl/mem_arb.sv
// Two-requester memory arbiter with rotating Imem priority, combinational
// grant/response steering and tag-based routing of load completions.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ABT_VEC_W = 4,
  parameter int MEM_TAG_W = mem_arb_pkg::MEM_TAG_W
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.slave  bus
);

  localparam logic [MEM_TAG_W-1:0] CNT_MAX = {MEM_TAG_W{1'b1}};

  logic [ABT_VEC_W-1:0] abt_vec_q, abt_vec_d;
  logic [MEM_TAG_W-1:0] outstanding_q, outstanding_d;
  logic                 tag_err_q, tag_err_d;

  logic       imem_win, dmem_win;
  logic [1:0] win_cmd;
  owner_e     win_owner;
  logic       alloc_en, alloc_busy, lk_valid, cmpl_en, same_tag_swap;
  owner_e     lk_owner;

  always_comb begin
    imem_win = 1'b0;
    dmem_win = 1'b0;
    if (abt_vec_q[0]) begin
      imem_win = (bus.Imem_cmd_i != BUS_NONE);
      dmem_win = !imem_win && (bus.Dmem_cmd_i != BUS_NONE);
    end else begin
      dmem_win = (bus.Dmem_cmd_i != BUS_NONE);
      imem_win = !dmem_win && (bus.Imem_cmd_i != BUS_NONE);
    end
    win_cmd         = imem_win ? bus.Imem_cmd_i : (dmem_win ? bus.Dmem_cmd_i : BUS_NONE);
    win_owner       = imem_win ? OWN_I : OWN_D;
    bus.mem_cmd_o   = win_cmd;
    bus.mem_addr_o  = imem_win ? bus.Imem_addr_i : (dmem_win ? bus.Dmem_addr_i : '0);
    bus.mem_data_o  = bus.Dmem_data_i;
    bus.Imem_response_o = imem_win ? bus.mem_response_i : '0;
    bus.Dmem_response_o = dmem_win ? bus.mem_response_i : '0;
  end

  assign alloc_en = (win_cmd == BUS_LOAD) && (bus.mem_response_i != '0);

  mem_tag_tbl #(.TAG_W(MEM_TAG_W)) u_tag_tbl (
    .clk           (clk),
    .rst           (rst),
    .alloc_en_i    (alloc_en),
    .alloc_tag_i   (bus.mem_response_i),
    .alloc_owner_i (win_owner),
    .alloc_busy_o  (alloc_busy),
    .lkup_tag_i    (bus.mem_tag_i),
    .clr_en_i      (lk_valid),
    .valid_o       (lk_valid),
    .owner_o       (lk_owner)
  );

  // Completion reads the pre-edge owner, so a same-tag reallocation still
  // routes the finishing load to whoever issued it.
  assign cmpl_en       = lk_valid && !rst;
  assign same_tag_swap = lk_valid && (bus.mem_tag_i == bus.mem_response_i);

  always_comb begin
    bus.Imem_tag_o  = (cmpl_en && lk_owner == OWN_I) ? bus.mem_tag_i  : '0;
    bus.Imem_data_o = (cmpl_en && lk_owner == OWN_I) ? bus.mem_data_i : '0;
    bus.Dmem_tag_o  = (cmpl_en && lk_owner == OWN_D) ? bus.mem_tag_i  : '0;
    bus.Dmem_data_o = (cmpl_en && lk_owner == OWN_D) ? bus.mem_data_i : '0;
  end

  always_comb begin
    abt_vec_d     = {abt_vec_q[0], abt_vec_q[ABT_VEC_W-1:1]};
    outstanding_d = outstanding_q;
    tag_err_d     = tag_err_q;
    case ({alloc_en, lk_valid})
      2'b10: begin
        if (outstanding_q == CNT_MAX) tag_err_d = 1'b1;
        else outstanding_d = outstanding_q + MEM_TAG_W'(1);
      end
      2'b01: begin
        if (outstanding_q == '0) tag_err_d = 1'b1;
        else outstanding_d = outstanding_q - MEM_TAG_W'(1);
      end
      default: ;
    endcase
    if (bus.mem_tag_i != '0 && !lk_valid) tag_err_d = 1'b1;
    if (alloc_en && alloc_busy && !same_tag_swap) tag_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abt_vec_q     <= ABT_VEC_W'(1);
      outstanding_q <= '0;
      tag_err_q     <= 1'b0;
    end else begin
      abt_vec_q     <= abt_vec_d;
      outstanding_q <= outstanding_d;
      tag_err_q     <= tag_err_d;
    end
  end

  assign bus.outstanding_o = outstanding_q;
  assign bus.tag_err_o     = tag_err_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: expected values go through a scoreboard queue
// and are popped and compared against DUT outputs at negedge + 1.
module tb_mem_arb;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arb_if bus ();

  mem_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb_q[$];

  task automatic expect_v(input logic [63:0] v);
    sb_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] obs);
    logic [63:0] e;
    checks++;
    assert (sb_q.size() != 0) else begin
      failures++;
      $error("FAIL %s: observed %0h, scoreboard empty", name, obs);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s: observed %0h expected %0h", name, obs, e);
      end
    end
  endtask

  task automatic cmp(input string name, input logic [63:0] obs, input logic [63:0] exp);
    expect_v(exp);
    check(name, obs);
  endtask

  task automatic drive(input logic [1:0] icmd, input logic [63:0] iaddr,
                       input logic [1:0] dcmd, input logic [63:0] daddr,
                       input logic [3:0] resp, input logic [3:0] tag,
                       input logic [63:0] mdata);
    @(negedge clk);
    bus.Imem_cmd_i     = icmd;
    bus.Imem_addr_i    = iaddr;
    bus.Dmem_cmd_i     = dcmd;
    bus.Dmem_addr_i    = daddr;
    bus.Dmem_data_i    = ~daddr;
    bus.mem_response_i = resp;
    bus.mem_tag_i      = tag;
    bus.mem_data_i     = mdata;
    #1;
    $display("txn t=%0t icmd=%0d dcmd=%0d resp=%0d tag=%0d data=%0h",
             $time, icmd, dcmd, resp, tag, mdata);
  endtask

  task automatic idle();
    drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 4'd0, 4'd0, 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.Imem_cmd_i = BUS_NONE;
    bus.Dmem_cmd_i = BUS_NONE;
    bus.mem_response_i = '0;
    bus.mem_tag_i = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic       iw;
    logic       own_i;
    logic [3:0] tg;

    bus.Imem_cmd_i = BUS_NONE;  bus.Imem_addr_i = '0;
    bus.Dmem_cmd_i = BUS_NONE;  bus.Dmem_addr_i = '0;  bus.Dmem_data_i = '0;
    bus.mem_response_i = '0;    bus.mem_data_i = '0;   bus.mem_tag_i = '0;

    #12;
    cmp("rst_outstanding", bus.outstanding_o, 0);
    cmp("rst_tag_err", bus.tag_err_o, 0);
    cmp("rst_mem_cmd", bus.mem_cmd_o, BUS_NONE);
    cmp("rst_imem_resp", bus.Imem_response_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Both requesters load every cycle: Imem wins every fourth cycle.
    for (int k = 0; k < 8; k++) begin
      drive(BUS_LOAD, 64'h1000 + k, BUS_LOAD, 64'h2000 + k, 4'(k + 1), 4'd0, 64'h0);
      iw = (k % 4 == 0);
      cmp("arb_cmd", bus.mem_cmd_o, BUS_LOAD);
      cmp("arb_addr", bus.mem_addr_o, iw ? 64'h1000 + k : 64'h2000 + k);
      cmp("arb_imem_resp", bus.Imem_response_o, iw ? k + 1 : 0);
      cmp("arb_dmem_resp", bus.Dmem_response_o, iw ? 0 : k + 1);
      cmp("arb_wdata", bus.mem_data_o, ~(64'h2000 + k));
    end
    idle();
    cmp("arb_idle_cmd", bus.mem_cmd_o, BUS_NONE);
    cmp("arb_idle_iresp", bus.Imem_response_o, 0);
    cmp("arb_idle_dresp", bus.Dmem_response_o, 0);
    cmp("arb_outstanding8", bus.outstanding_o, 8);
    cmp("arb_tag_err", bus.tag_err_o, 0);

    // Drain tags 1..8; tags 1 and 5 belong to Imem.
    for (int t = 1; t <= 8; t++) begin
      drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 4'd0, 4'(t), 64'hC0DE_0000 + t);
      own_i = (t == 1 || t == 5);
      cmp("drain_itag", bus.Imem_tag_o, own_i ? t : 0);
      cmp("drain_dtag", bus.Dmem_tag_o, own_i ? 0 : t);
      cmp("drain_data", own_i ? bus.Imem_data_o : bus.Dmem_data_o, 64'hC0DE_0000 + t);
    end
    idle();
    cmp("drain_outstanding", bus.outstanding_o, 0);
    cmp("drain_tag_err", bus.tag_err_o, 0);

    // Dmem load, tag 5, completes three cycles later.
    do_reset();
    drive(BUS_NONE, 64'h0, BUS_LOAD, 64'h3000, 4'd5, 4'd0, 64'h0);
    cmp("ld5_dresp", bus.Dmem_response_o, 5);
    cmp("ld5_iresp", bus.Imem_response_o, 0);
    idle();
    cmp("ld5_outstanding1", bus.outstanding_o, 1);
    idle();
    drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 4'd0, 4'd5, 64'hDEAD);
    cmp("ld5_dtag", bus.Dmem_tag_o, 5);
    cmp("ld5_ddata", bus.Dmem_data_o, 64'hDEAD);
    cmp("ld5_itag", bus.Imem_tag_o, 0);
    idle();
    cmp("ld5_outstanding0", bus.outstanding_o, 0);
    cmp("ld5_tag_err", bus.tag_err_o, 0);

    // Accepted store leaves no entry; its tag returning is a protocol error.
    drive(BUS_NONE, 64'h0, BUS_STORE, 64'h4000, 4'd3, 4'd0, 64'h0);
    cmp("st3_cmd", bus.mem_cmd_o, BUS_STORE);
    cmp("st3_dresp", bus.Dmem_response_o, 3);
    idle();
    cmp("st3_outstanding", bus.outstanding_o, 0);
    drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 4'd0, 4'd3, 64'h1234);
    cmp("st3_itag", bus.Imem_tag_o, 0);
    cmp("st3_dtag", bus.Dmem_tag_o, 0);
    cmp("st3_err_pre", bus.tag_err_o, 0);
    idle();
    cmp("st3_err_set", bus.tag_err_o, 1);
    idle();
    cmp("st3_err_sticky", bus.tag_err_o, 1);

    // Same-tag completion and reallocation in one cycle.
    do_reset();
    drive(BUS_LOAD, 64'h5000, BUS_NONE, 64'h0, 4'd7, 4'd0, 64'h0);
    cmp("swap_iresp", bus.Imem_response_o, 7);
    drive(BUS_LOAD, 64'h5008, BUS_LOAD, 64'h6000, 4'd7, 4'd7, 64'hBEEF);
    cmp("swap_dresp", bus.Dmem_response_o, 7);
    cmp("swap_iresp0", bus.Imem_response_o, 0);
    cmp("swap_itag", bus.Imem_tag_o, 7);
    cmp("swap_idata", bus.Imem_data_o, 64'hBEEF);
    cmp("swap_dtag", bus.Dmem_tag_o, 0);
    idle();
    cmp("swap_outstanding", bus.outstanding_o, 1);
    drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 4'd0, 4'd7, 64'hF00D);
    cmp("swap_new_dtag", bus.Dmem_tag_o, 7);
    cmp("swap_new_itag", bus.Imem_tag_o, 0);
    idle();
    cmp("swap_outstanding0", bus.outstanding_o, 0);

    // Asynchronous reset with tags 2 and 9 outstanding.
    do_reset();
    drive(BUS_LOAD, 64'h7000, BUS_NONE, 64'h0, 4'd2, 4'd0, 64'h0);
    cmp("ar_iresp", bus.Imem_response_o, 2);
    drive(BUS_NONE, 64'h0, BUS_LOAD, 64'h7100, 4'd9, 4'd0, 64'h0);
    cmp("ar_dresp", bus.Dmem_response_o, 9);
    idle();
    cmp("ar_outstanding2", bus.outstanding_o, 2);
    #2;
    rst = 1'b1;
    bus.mem_tag_i = 4'd9;
    bus.Imem_cmd_i = BUS_LOAD;
    bus.Imem_addr_i = 64'h7200;
    bus.mem_response_i = 4'd6;
    #1;
    cmp("ar_outstanding_clr", bus.outstanding_o, 0);
    cmp("ar_tag_err_clr", bus.tag_err_o, 0);
    cmp("ar_itag_rst", bus.Imem_tag_o, 0);
    cmp("ar_dtag_rst", bus.Dmem_tag_o, 0);
    cmp("ar_cmd_rst", bus.mem_cmd_o, BUS_LOAD);
    cmp("ar_iresp_rst", bus.Imem_response_o, 6);
    bus.Imem_cmd_i = BUS_NONE;
    bus.mem_response_i = '0;
    bus.mem_tag_i = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 4'd0, 4'd2, 64'h2222);
    cmp("ar_stale_itag", bus.Imem_tag_o, 0);
    cmp("ar_stale_dtag", bus.Dmem_tag_o, 0);
    cmp("ar_err_pre", bus.tag_err_o, 0);
    idle();
    cmp("ar_err_set", bus.tag_err_o, 1);

    // Fill all 15 tags, then one more allocation: count saturates at 15.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      tg = (i <= 15) ? 4'(i) : 4'd1;
      drive(BUS_NONE, 64'h0, BUS_LOAD, 64'h8000 + i, tg, 4'd0, 64'h0);
      if (i == 16) begin
        cmp("sat_full", bus.outstanding_o, 15);
        cmp("sat_err_pre", bus.tag_err_o, 0);
      end
    end
    idle();
    cmp("sat_hold", bus.outstanding_o, 15);
    cmp("sat_err", bus.tag_err_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
